// File: rtl/rot_dir_fsm.sv
// Purpose: quadrature direction FSM; one count strobe per legal CW/CCW cycle, error on two-bit jumps (ROT_ERR_STICKY_EN makes error sticky).
// Latency: enable/up_down/error are registered, 1 cycle after the sampled quad_ctl code.
// Backpressure: none; quad_ctl is consumed every cycle and the counter must accept every enable strobe.
module rot_dir_fsm #(
  parameter int QUIET_CYCLES = 4,
  parameter bit CW_IS_UP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] quad_ctl,
  output logic       enable,
  output logic       up_down,
  output logic       error
);

  localparam int              CNT_W      = $clog2(QUIET_CYCLES + 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] QUIET_MAX  = CNT_W'(QUIET_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] Q_00 = 2'b00;
  localparam logic [1:0] Q_01 = 2'b01;
  localparam logic [1:0] Q_10 = 2'b10;
  localparam logic [1:0] Q_11 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CW1  = 3'd1,
    S_CW2  = 3'd2,
    S_CW3  = 3'd3,
    S_CCW1 = 3'd4,
    S_CCW2 = 3'd5,
    S_CCW3 = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] quiet_cnt;
  logic [CNT_W-1:0] quiet_cnt_nxt;
  logic             enable_nxt;
  logic             up_down_nxt;
  logic             error_nxt;
  logic             count_cw;
  logic             count_ccw;

  // State, quiet counter and output registers; synchronous reset drops any partial rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      quiet_cnt <= '0;
      enable    <= 1'b0;
      up_down   <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= next_state;
      quiet_cnt <= quiet_cnt_nxt;
      enable    <= enable_nxt;
      up_down   <= up_down_nxt;
      error     <= error_nxt;
    end
  end

  // Next-state: walk the Gray sequence, allow single steps back, any two-bit jump goes to ERR.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        case (quad_ctl)
          Q_01:    next_state = S_CW1;
          Q_10:    next_state = S_CCW1;
          Q_11:    next_state = S_ERR;
          default: next_state = S_IDLE;
        endcase
      end
      S_CW1: begin
        case (quad_ctl)
          Q_11:    next_state = S_CW2;
          Q_00:    next_state = S_IDLE;
          Q_10:    next_state = S_ERR;
          default: next_state = S_CW1;
        endcase
      end
      S_CW2: begin
        case (quad_ctl)
          Q_10:    next_state = S_CW3;
          Q_01:    next_state = S_CW1;
          Q_00:    next_state = S_ERR;
          default: next_state = S_CW2;
        endcase
      end
      S_CW3: begin
        case (quad_ctl)
          Q_00:    next_state = S_IDLE;
          Q_11:    next_state = S_CW2;
          Q_01:    next_state = S_ERR;
          default: next_state = S_CW3;
        endcase
      end
      S_CCW1: begin
        case (quad_ctl)
          Q_11:    next_state = S_CCW2;
          Q_00:    next_state = S_IDLE;
          Q_01:    next_state = S_ERR;
          default: next_state = S_CCW1;
        endcase
      end
      S_CCW2: begin
        case (quad_ctl)
          Q_01:    next_state = S_CCW3;
          Q_10:    next_state = S_CCW1;
          Q_00:    next_state = S_ERR;
          default: next_state = S_CCW2;
        endcase
      end
      S_CCW3: begin
        case (quad_ctl)
          Q_00:    next_state = S_IDLE;
          Q_11:    next_state = S_CCW2;
          Q_10:    next_state = S_ERR;
          default: next_state = S_CCW3;
        endcase
      end
      S_ERR: begin
        // Leave on the edge where the quiet count would reach QUIET_CYCLES.
        if (quad_ctl == Q_00 && quiet_cnt == QUIET_LAST) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs: strobe on completion of the last quarter, direction load, error flag, quiet counting.
  always_comb begin
    count_cw      = (state == S_CW3)  && (quad_ctl == Q_00);
    count_ccw     = (state == S_CCW3) && (quad_ctl == Q_00);
    enable_nxt    = count_cw || count_ccw;
    up_down_nxt   = up_down;
    if (count_cw) begin
      up_down_nxt = CW_IS_UP;
    end else if (count_ccw) begin
      up_down_nxt = ~CW_IS_UP;
    end
`ifdef ROT_ERR_STICKY_EN
    error_nxt     = error || (next_state == S_ERR);
`else
    error_nxt     = (next_state == S_ERR);
`endif
    quiet_cnt_nxt = '0;
    if (state == S_ERR && quad_ctl == Q_00) begin
      quiet_cnt_nxt = (quiet_cnt == QUIET_MAX) ? quiet_cnt : quiet_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_rot_dir_fsm.sv
// Purpose: self-checking bench for rot_dir_fsm using a displacement-based reference model.
// Latency: model predicts registered outputs one cycle after each sampled code.
// Backpressure: none; stimulus drives a new code (or holds) every cycle.
module tb_rot_dir_fsm;

  localparam int QC = 4;
  localparam bit CWU = 1'b1;

  logic       clk;
  logic       rst;
  logic [1:0] quad_ctl;
  logic       enable;
  logic       up_down;
  logic       error;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  int dut_pulses = 0;

  // reference model state: signed displacement from the 00 detent
  logic [1:0] m_prev;
  int         m_prog;
  bit         m_err;
  int         m_quiet;
  int         m_pulses = 0;
  logic       exp_en;
  logic       exp_ud;
  logic       exp_error;

  rot_dir_fsm #(.QUIET_CYCLES(QC), .CW_IS_UP(CWU)) dut (
    .clk      (clk),
    .rst      (rst),
    .quad_ctl (quad_ctl),
    .enable   (enable),
    .up_down  (up_down),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ph(input logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] code_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [1:0] q);
    int d;
    if (r) begin
      m_prev = 2'b00; m_prog = 0; m_err = 0; m_quiet = 0;
      exp_en = 0; exp_ud = 0; exp_error = 0;
    end else begin
      exp_en = 0;
      if (m_err) begin
        if (q == 2'b00) begin
          m_quiet++;
          if (m_quiet >= QC) begin
            m_err = 0; m_prog = 0; m_prev = 2'b00;
          end
        end else begin
          m_quiet = 0;
        end
      end else begin
        d = (ph(q) - ph(m_prev)) & 3;
        if (d == 2) begin
          m_err = 1; m_quiet = 0;
        end else begin
          if (d == 1) m_prog++;
          else if (d == 3) m_prog--;
          m_prev = q;
          if (m_prog == 4) begin
            exp_en = 1; exp_ud = CWU; m_prog = 0; m_pulses++;
          end else if (m_prog == -4) begin
            exp_en = 1; exp_ud = ~CWU; m_prog = 0; m_pulses++;
          end
        end
      end
`ifdef ROT_ERR_STICKY_EN
      exp_error = exp_error | m_err;
`else
      exp_error = m_err;
`endif
    end
  endtask

  // model tracks what the DUT samples on each rising edge
  always @(posedge clk) model_step(rst, quad_ctl);

  // compare DUT outputs against the model mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("enable", int'(enable), int'(exp_en));
      chk("up_down", int'(up_down), int'(exp_ud));
      chk("error", int'(error), int'(exp_error));
      if (enable === 1'b1) dut_pulses++;
    end
  end

  task automatic hold(input logic [1:0] q, input int n);
    repeat (n) begin
      quad_ctl = q;
      @(negedge clk);
    end
  endtask

  task automatic cw_cycle(input int n);
    hold(2'b00, n); hold(2'b01, n); hold(2'b11, n); hold(2'b10, n); hold(2'b00, n);
  endtask

  task automatic ccw_cycle(input int n);
    hold(2'b00, n); hold(2'b10, n); hold(2'b11, n); hold(2'b01, n); hold(2'b00, n);
  endtask

  int p0;
  int mp0;
  int cur;
  int r;

  initial begin
    rst = 1'b1;
    quad_ctl = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_enable", int'(enable), 0);
    chk("rst_up_down", int'(up_down), 0);
    chk("rst_error", int'(error), 0);
    rst = 1'b0;
    chk_en = 1;

    // CW full cycle: pulse one cycle after the final 00
    p0 = dut_pulses; mp0 = m_pulses;
    hold(2'b00, 3); hold(2'b01, 3); hold(2'b11, 3); hold(2'b10, 3); hold(2'b00, 1);
    chk("cw_enable_lat1", int'(enable), 1);
    chk("cw_up_down", int'(up_down), 1);
    hold(2'b00, 2);
    chk("cw_pulses", dut_pulses - p0, 1);
    chk("cw_model_pulses", m_pulses - mp0, 1);
    chk("cw_error", int'(error), 0);

    // two back-to-back CCW cycles
    p0 = dut_pulses; mp0 = m_pulses;
    ccw_cycle(3);
    ccw_cycle(3);
    hold(2'b00, 2);
    chk("ccw_pulses", dut_pulses - p0, 2);
    chk("ccw_model_pulses", m_pulses - mp0, 2);
    chk("ccw_up_down", int'(up_down), 0);

    // back-out gives nothing; reversal then completion gives one CW pulse
    p0 = dut_pulses;
    hold(2'b00, 2); hold(2'b01, 2); hold(2'b11, 2); hold(2'b01, 2); hold(2'b00, 3);
    chk("backout_pulses", dut_pulses - p0, 0);
    chk("backout_error", int'(error), 0);
    hold(2'b01, 2); hold(2'b11, 2); hold(2'b10, 2); hold(2'b11, 2); hold(2'b10, 2); hold(2'b00, 3);
    chk("reversal_pulses", dut_pulses - p0, 1);
    chk("reversal_up_down", int'(up_down), 1);

    // illegal 00->11 jump and quiet recovery
    hold(2'b00, 2);
    hold(2'b11, 1);
    chk("jump_error_set", int'(error), 1);
    hold(2'b00, 3);
    chk("quiet3_error", int'(error), 1);
    hold(2'b00, 1);
`ifdef ROT_ERR_STICKY_EN
    chk("quiet4_error", int'(error), 1);
`else
    chk("quiet4_error", int'(error), 0);
`endif
    p0 = dut_pulses;
    cw_cycle(2);
    hold(2'b00, 2);
    chk("post_err_pulses", dut_pulses - p0, 1);

    // reset mid-rotation abandons it
    p0 = dut_pulses;
    hold(2'b00, 2); hold(2'b01, 2); hold(2'b11, 2);
    rst = 1'b1; quad_ctl = 2'b10;
    @(negedge clk);
    rst = 1'b0;
    hold(2'b00, 3);
    chk("midrst_pulses", dut_pulses - p0, 0);
    chk("midrst_enable", int'(enable), 0);
    chk("midrst_up_down", int'(up_down), 0);
    chk("midrst_error", int'(error), 0);

    // illegal 01->10 jump, recover, complete a CW cycle
    p0 = dut_pulses;
    hold(2'b01, 2); hold(2'b10, 1); hold(2'b00, QC + 1);
    cw_cycle(2);
    hold(2'b00, 2);
    chk("sticky_pulses", dut_pulses - p0, 1);
`ifdef ROT_ERR_STICKY_EN
    chk("sticky_error", int'(error), 1);
`else
    chk("sticky_error", int'(error), 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("sticky_rst_error", int'(error), 0);

    // randomized walk: mostly legal steps, occasional jumps and resets
    cur = 0;
    quad_ctl = 2'b00;
    repeat (3000) begin
      r = $urandom_range(0, 39);
      if (r < 14) cur = cur + 1;
      else if (r < 26) cur = cur - 1;
      else if (r < 37) cur = cur;
      else if (r < 39) cur = int'($urandom_range(0, 3));
      else begin
        rst = 1'b1;
        cur = 0;
      end
      quad_ctl = code_of(cur);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end
    hold(2'b00, QC + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
